hub75_capture: RTL and testbench

- Panel-side receiver for the HUB75 stream produced by our LED matrix controller.
- Oversamples display_clk, latch, oe, row address and the two 4-bit data lanes with the system clock.
- Rebuilds each shifted row in a ping-pong line buffer, then writes it back out in framebuffer address format: {half, row, col}, 4-bit pixels.
- Used as a loopback checker and as the capture side of a frame-grabber path.

---
 rtl/hub75_pkg.sv | 26 ++
 rtl/hub75_input_sync.sv | 46 ++++
 rtl/hub75_capture.sv | 208 ++++++++++++++++++++
 tb/tb_hub75_capture.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 capture path: flush FSM states,
// field widths and the framebuffer address packing helper.
package hub75_pkg;

  localparam int ROW_W     = 5;
  localparam int COL_W     = 6;
  localparam int PIX_W     = 4;
  localparam int FB_ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    WR_A,
    WR_B,
    DONE
  } flush_state_t;

  // Framebuffer address layout is {half, row, col}; half 0 is the upper lane.
  function automatic logic [FB_ADDR_W-1:0] fb_addr(
    input logic             half,
    input logic [ROW_W-1:0] row,
    input logic [COL_W-1:0] col
  );
    return {half, row, col};
  endfunction

endpackage

// File: rtl/hub75_input_sync.sv
// Oversampling front end: one identical SYNC_STAGES chain per HUB75 input so
// data, row and oe stay aligned with the hub_clk/hub_latch edge strobes.
module hub75_input_sync
  import hub75_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hub_clk,
  input  logic             hub_latch,
  input  logic             hub_oe,
  input  logic [ROW_W-1:0] hub_row,
  input  logic [PIX_W-1:0] hub_data_a,
  input  logic [PIX_W-1:0] hub_data_b,
  output logic             clk_rise,
  output logic             latch_rise,
  output logic             oe_sync,
  output logic [ROW_W-1:0] row_sync,
  output logic [PIX_W-1:0] data_a_sync,
  output logic [PIX_W-1:0] data_b_sync
);

  localparam int W = 3 + ROW_W + 2 * PIX_W;

  logic [W-1:0] stage [SYNC_STAGES];
  logic         clk_last;
  logic         latch_last;

  // NOTE: every stage uses <= so the chain advances one flop per clock instead of collapsing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= {hub_clk, hub_latch, hub_oe, hub_row, hub_data_a, hub_data_b};
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign {clk_last, latch_last, oe_sync, row_sync, data_a_sync, data_b_sync} = stage[SYNC_STAGES-1];

  // The newer of the last two samples is high while the older is low.
  assign clk_rise   = stage[SYNC_STAGES-2][W-1] && !clk_last;
  assign latch_rise = stage[SYNC_STAGES-2][W-2] && !latch_last;

endmodule

// File: rtl/hub75_capture.sv
// HUB75 panel-side receiver: ping-pong line capture and framebuffer write-back.
// Optional oe-low statistics are built when HUB75_OE_STATS_EN is defined.
module hub75_capture
  import hub75_pkg::*;
#(
  parameter int ROWS        = 32,
  parameter int COLUMNS     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hub_clk,
  input  logic                 hub_latch,
  input  logic                 hub_oe,
  input  logic [ROW_W-1:0]     hub_row,
  input  logic [PIX_W-1:0]     hub_data_a,
  input  logic [PIX_W-1:0]     hub_data_b,
  output logic [FB_ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]     wr_data,
  output logic                 wr_en,
  input  logic                 wr_ready,
  output logic                 row_done,
  output logic                 overrun,
  output logic                 long_line
`ifdef HUB75_OE_STATS_EN
  ,
  output logic [15:0]          oe_low_cycles,
  output logic                 oe_stat_valid
`endif
);

  if (ROWS > (1 << ROW_W) || COLUMNS > (1 << COL_W) || SYNC_STAGES < 2) begin : g_bad_cfg
    $error("hub75_capture: unsupported ROWS/COLUMNS/SYNC_STAGES");
  end

  localparam int                CNT_W    = $clog2(COLUMNS + 1);
  localparam logic [CNT_W-1:0]  LINE_MAX = CNT_W'(COLUMNS);

  logic             clk_rise, latch_rise, oe_sync;
  logic [ROW_W-1:0] row_sync;
  logic [PIX_W-1:0] data_a_sync, data_b_sync;

  hub75_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .hub_clk    (hub_clk),
    .hub_latch  (hub_latch),
    .hub_oe     (hub_oe),
    .hub_row    (hub_row),
    .hub_data_a (hub_data_a),
    .hub_data_b (hub_data_b),
    .clk_rise   (clk_rise),
    .latch_rise (latch_rise),
    .oe_sync    (oe_sync),
    .row_sync   (row_sync),
    .data_a_sync(data_a_sync),
    .data_b_sync(data_b_sync)
  );

  logic [2*PIX_W-1:0] line_mem [2][COLUMNS];
  logic [1:0]         bank_full;
  logic [ROW_W-1:0]   bank_row [2];
  logic [CNT_W-1:0]   bank_len [2];
  logic               shift_bank, flush_bank;
  logic [CNT_W-1:0]   col_cnt, col_next;
  logic [COL_W-1:0]   fl_col;
  logic               shift_take, latch_take, latch_keep, last_col;
  logic [2*PIX_W-1:0] flush_pix;
  flush_state_t       state, state_next;

  // A clock edge landing with a latch edge is counted before the latch sees the length.
  always_comb begin
    shift_take = clk_rise && (col_cnt != LINE_MAX);
    col_next   = col_cnt + CNT_W'(shift_take);
    latch_take = latch_rise && (col_next != '0);
    latch_keep = latch_take && !bank_full[shift_bank];
  end

  assign last_col  = (CNT_W'(fl_col) == bank_len[flush_bank] - CNT_W'(1));
  assign flush_pix = line_mem[flush_bank][fl_col];

  // NOTE: the line buffer has no reset; bank_full gates every read, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (shift_take && !bank_full[shift_bank])
      line_mem[shift_bank][col_cnt[COL_W-1:0]] <= {data_a_sync, data_b_sync};
  end

  // A bank that is still full or flushing refuses new pixels and drops its line at latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt    <= '0;
      shift_bank <= 1'b0;
      flush_bank <= 1'b0;
      bank_full  <= '0;
      fl_col     <= '0;
      overrun    <= 1'b0;
      long_line  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        bank_row[b] <= '0;
        bank_len[b] <= '0;
      end
    end else begin
      if (clk_rise && !shift_take) long_line <= 1'b1;

      if (latch_take) begin
        col_cnt <= '0;
        if (latch_keep) begin
          bank_full[shift_bank] <= 1'b1;
          bank_row[shift_bank]  <= row_sync;
          bank_len[shift_bank]  <= col_next;
          shift_bank            <= ~shift_bank;
        end else begin
          overrun <= 1'b1;
        end
      end else begin
        col_cnt <= col_next;
      end

      case (state)
        WR_B: if (wr_ready) fl_col <= last_col ? '0 : fl_col + 1'b1;
        DONE: begin
          bank_full[flush_bank] <= 1'b0;
          flush_bank            <= ~flush_bank;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Banks fill alternately, so the oldest full bank is always flush_bank.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bank_full[flush_bank]) state_next = WR_A;
      WR_A:    if (wr_ready) state_next = WR_B;
      WR_B:    if (wr_ready) state_next = last_col ? DONE : WR_A;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so this block never infers a latch.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    row_done = 1'b0;
    case (state)
      WR_A: begin
        wr_en   = 1'b1;
        wr_addr = fb_addr(1'b0, bank_row[flush_bank], fl_col);
        wr_data = flush_pix[2*PIX_W-1:PIX_W];
      end
      WR_B: begin
        wr_en   = 1'b1;
        wr_addr = fb_addr(1'b1, bank_row[flush_bank], fl_col);
        wr_data = flush_pix[PIX_W-1:0];
      end
      DONE:    row_done = 1'b1;
      default: ;
    endcase
  end

`ifdef HUB75_OE_STATS_EN
  logic [15:0] oe_cnt;
  logic        oe_armed, oe_seen_low;

  always_ff @(posedge clk) begin
    if (rst) begin
      oe_low_cycles <= '0;
      oe_stat_valid <= 1'b0;
      oe_cnt        <= '0;
      oe_armed      <= 1'b0;
      oe_seen_low   <= 1'b0;
    end else begin
      oe_stat_valid <= 1'b0;
      if (latch_take) begin
        if (oe_armed) begin
          oe_low_cycles <= oe_cnt;
          oe_stat_valid <= 1'b1;
        end
        oe_armed    <= latch_keep;
        oe_cnt      <= '0;
        oe_seen_low <= 1'b0;
      end else if (oe_armed) begin
        if (!oe_sync) begin
          if (oe_cnt != 16'hFFFF) oe_cnt <= oe_cnt + 16'd1;
          oe_seen_low <= 1'b1;
        end else if (oe_seen_low && clk_rise) begin
          oe_low_cycles <= oe_cnt;
          oe_stat_valid <= 1'b1;
          oe_armed      <= 1'b0;
        end
      end
    end
  end
`else
  // Without the statistics block the oe level is deliberately ignored.
  logic oe_unused;
  assign oe_unused = oe_sync;
`endif

endmodule

// File: tb/tb_hub75_capture.sv
// Directed bench for hub75_capture: a table of line-capture vectors plus
// hand-written overrun and reset-mid-flush sequences.
module tb_hub75_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hub_clk = 1'b0;
  logic        hub_latch = 1'b0;
  logic        hub_oe = 1'b1;
  logic [4:0]  hub_row = '0;
  logic [3:0]  hub_data_a = '0;
  logic [3:0]  hub_data_b = '0;
  logic [11:0] wr_addr;
  logic [3:0]  wr_data;
  logic        wr_en;
  logic        wr_ready = 1'b1;
  logic        row_done;
  logic        overrun;
  logic        long_line;
`ifdef HUB75_OE_STATS_EN
  logic [15:0] oe_low_cycles;
  logic        oe_stat_valid;
`endif

  always #5 clk = ~clk;

  hub75_capture dut (
    .clk       (clk),
    .rst       (rst),
    .hub_clk   (hub_clk),
    .hub_latch (hub_latch),
    .hub_oe    (hub_oe),
    .hub_row   (hub_row),
    .hub_data_a(hub_data_a),
    .hub_data_b(hub_data_b),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .wr_ready  (wr_ready),
    .row_done  (row_done),
    .overrun   (overrun),
    .long_line (long_line)
`ifdef HUB75_OE_STATS_EN
    ,
    .oe_low_cycles(oe_low_cycles),
    .oe_stat_valid(oe_stat_valid)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Sink readiness: steady level, or toggling 1-0-1-0 every cycle.
  bit   tog_mode    = 1'b0;
  logic ready_level = 1'b1;
  always @(posedge clk) begin
    #1;
    wr_ready = tog_mode ? ~wr_ready : ready_level;
  end

  // Write monitor / scoreboard capture, sampled on the falling edge.
  logic [11:0] wq_addr[$];
  logic [3:0]  wq_data[$];
  logic [11:0] exp_addr[$];
  logic [3:0]  exp_data[$];
  int          rd_cnt = 0, stall_err = 0, done_after = 0, span = 0;
  int          cyc = 0, first_cyc = 0;
  bit          in_row = 1'b0, stalled = 1'b0;
  logic [11:0] held_addr = '0;
  logic [3:0]  held_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (stalled && (!wr_en || wr_addr !== held_addr || wr_data !== held_data)) stall_err++;
    stalled   = wr_en && !wr_ready;
    held_addr = wr_addr;
    held_data = wr_data;
    if (wr_en && wr_ready) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
    if (wr_en && !in_row) begin
      in_row    = 1'b1;
      first_cyc = cyc;
    end
    if (row_done) begin
      rd_cnt++;
      done_after = wq_addr.size();
      span       = cyc - first_cyc + 1;
      in_row     = 1'b0;
    end else if (!wr_en) begin
      in_row = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hub_pulse(input logic [3:0] v);
    hub_data_a = v;
    hub_data_b = ~v;
    hub_oe     = ~hub_oe;
    hub_clk    = 1'b0;
    tick(2);
    hub_clk = 1'b1;
    tick(2);
    hub_clk = 1'b0;
  endtask

  task automatic run_line(input int row, input int n);
    hub_row = 5'(row);
    for (int i = 0; i < n; i++) hub_pulse(4'(i));
    tick(2);
    hub_latch = 1'b1;
    tick(2);
    hub_latch = 1'b0;
    tick(2);
  endtask

  // Expected writes for one line: upper lane then lower lane per column.
  task automatic expect_line(input int row, input int n);
    int         m;
    logic [3:0] v;
    m = (n > 64) ? 64 : n;
    for (int c = 0; c < m; c++) begin
      v = 4'(c);
      exp_addr.push_back(12'((row << 6) | c));
      exp_data.push_back(v);
      exp_addr.push_back(12'(2048 | (row << 6) | c));
      exp_data.push_back(~v);
    end
  endtask

  function automatic int content_errs();
    int e = 0;
    for (int k = 0; k < exp_addr.size(); k++) begin
      if (k >= wq_addr.size()) e++;
      else if (wq_addr[k] !== exp_addr[k] || wq_data[k] !== exp_data[k]) e++;
    end
    return e;
  endfunction

  task automatic clear_sb();
    wq_addr.delete();
    wq_data.delete();
    exp_addr.delete();
    exp_data.delete();
    rd_cnt     = 0;
    stall_err  = 0;
    done_after = 0;
    span       = 0;
  endtask

  task automatic wait_rows(input int n, input int budget, input string name);
    int c = 0;
    while (rd_cnt < n && c < budget) begin
      tick(1);
      c++;
    end
    check({name, "_wait"}, 32'(rd_cnt >= n), 32'd1);
    tick(20);
  endtask

  typedef struct {
    int          row;
    int          npulse;
    bit          tog;
    int          exp_writes;
    logic [11:0] exp_last;
    bit          exp_long;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int c;
    string nm;

    vecs[0] = '{row: 5,  npulse: 64, tog: 1'b0, exp_writes: 128, exp_last: 12'h97F, exp_long: 1'b0};
    vecs[1] = '{row: 5,  npulse: 64, tog: 1'b1, exp_writes: 128, exp_last: 12'h97F, exp_long: 1'b0};
    vecs[2] = '{row: 31, npulse: 10, tog: 1'b0, exp_writes: 20,  exp_last: 12'hFC9, exp_long: 1'b0};
    vecs[3] = '{row: 31, npulse: 0,  tog: 1'b0, exp_writes: 0,   exp_last: 12'h000, exp_long: 1'b0};
    vecs[4] = '{row: 2,  npulse: 70, tog: 1'b0, exp_writes: 128, exp_last: 12'h8BF, exp_long: 1'b1};

    // Reset state
    tick(4);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_row_done", 32'(row_done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_long_line", 32'(long_line), 32'd0);
    rst = 1'b0;
    tick(2);

    // Table-driven line captures
    for (int i = 0; i < 5; i++) begin
      clear_sb();
      tog_mode    = vecs[i].tog;
      ready_level = 1'b1;
      expect_line(vecs[i].row, vecs[i].npulse);
      run_line(vecs[i].row, vecs[i].npulse);
      nm = $sformatf("v%0d", i);
      wait_rows(vecs[i].exp_writes > 0 ? 1 : 0, 800, nm);
      check({nm, "_writes"}, 32'(wq_addr.size()), 32'(vecs[i].exp_writes));
      check({nm, "_rows"}, 32'(rd_cnt), vecs[i].exp_writes > 0 ? 32'd1 : 32'd0);
      check({nm, "_content_errs"}, 32'(content_errs()), 32'd0);
      check({nm, "_stall_errs"}, 32'(stall_err), 32'd0);
      check({nm, "_overrun"}, 32'(overrun), 32'd0);
      check({nm, "_long_line"}, 32'(long_line), 32'(vecs[i].exp_long));
      if (vecs[i].exp_writes > 0) begin
        check({nm, "_last_addr"}, 32'(wq_addr[wq_addr.size()-1]), 32'(vecs[i].exp_last));
        check({nm, "_done_after_last"}, 32'(done_after), 32'(vecs[i].exp_writes));
        if (!vecs[i].tog) check({nm, "_span"}, 32'(span), 32'(vecs[i].exp_writes + 1));
      end
    end
    tog_mode = 1'b0;

    // Overrun: three rows with the sink stalled, third one dropped
    clear_sb();
    ready_level = 1'b0;
    tick(2);
    run_line(1, 64);
    run_line(2, 64);
    run_line(3, 64);
    tick(10);
    check("ovr_held_writes", 32'(wq_addr.size()), 32'd0);
    check("ovr_wr_en_held", 32'(wr_en), 32'd1);
    check("ovr_flag", 32'(overrun), 32'd1);
    expect_line(1, 64);
    expect_line(2, 64);
    ready_level = 1'b1;
    wait_rows(2, 1000, "ovr");
    check("ovr_rows", 32'(rd_cnt), 32'd2);
    check("ovr_writes", 32'(wq_addr.size()), 32'd256);
    check("ovr_content_errs", 32'(content_errs()), 32'd0);
    check("ovr_stall_errs", 32'(stall_err), 32'd0);

    // Reset at the 40th accept of a flush
    clear_sb();
    run_line(7, 64);
    c = 0;
    while (wq_addr.size() < 40 && c < 400) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("rmf_reached_40", 32'(wq_addr.size() >= 40), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rmf_wr_en_next", 32'(wr_en), 32'd0);
    check("rmf_wr_addr", 32'(wr_addr), 32'd0);
    check("rmf_wr_data", 32'(wr_data), 32'd0);
    check("rmf_row_done", 32'(row_done), 32'd0);
    check("rmf_overrun", 32'(overrun), 32'd0);
    check("rmf_long_line", 32'(long_line), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(20);
    check("rmf_no_row_done", 32'(rd_cnt), 32'd0);
    check("rmf_writes", 32'(wq_addr.size()), 32'd40);
    check("rmf_wr_en_idle", 32'(wr_en), 32'd0);

    clear_sb();
    expect_line(9, 64);
    run_line(9, 64);
    wait_rows(1, 800, "post");
    check("post_writes", 32'(wq_addr.size()), 32'd128);
    check("post_rows", 32'(rd_cnt), 32'd1);
    check("post_content_errs", 32'(content_errs()), 32'd0);
    check("post_last_addr", 32'(wq_addr.size() > 0 ? wq_addr[wq_addr.size()-1] : 12'h0), 32'h0A7F);
    check("post_overrun", 32'(overrun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
